line_memory: RTL
================

Name: line_memory

Overview:
Parametrised main memory serving whole cache lines to the cache controller. It replaces the fixed 64x32 negedge block-read memory with a configurable rising-edge memory. The new block adds a valid/ready request/response handshake, programmable access latency, full-line write-back, and backpressure. It sits behind the direct-mapped (and later set-associative) cache controllers as the backing store.

Parameters:
DATA_W, 32, bits per memory word
ADDR_W, 32, request address width (word address)
DEPTH_LOG2, 6, log2 of number of words (64 words)
LINE_LOG2, 2, log2 of words per line (4 words, 128-bit line)
LATENCY, 2, extra wait cycles between request accept and array access (0 allowed)
INIT_FILE, "", hex file loaded into array at elaboration via $readmemh; empty means no preload

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_write  in  1  1 = line write, 0 = line read
req_addr  in  ADDR_W  word address; line base = req_addr[DEPTH_LOG2-1:LINE_LOG2]
req_wdata  in  DATA_W<<LINE_LOG2  write line
resp_valid  out  1  response present (read data or write ack)
resp_ready  in  1  consumer accepts response
resp_rdata  out  DATA_W<<LINE_LOG2  read line
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high (rst).
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, latency counter 0. After the reset edge, req_ready = 1 and busy = 0.
- Array contents are never touched by rst.
- Address decode: req_addr bits above DEPTH_LOG2-1 are ignored, so addresses wrap modulo depth. Low LINE_LOG2 bits are ignored; the access always covers the whole aligned line.
- Line packing: word 0 of the line occupies the most significant DATA_W slice; word (2^LINE_LOG2 - 1) occupies the LSBs. The same packing applies to req_wdata and resp_rdata.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready = 1. On req_valid && req_ready, latch addr, write and wdata; load cnt <= LATENCY; go to WAIT.
  - WAIT: req_ready = 0. If cnt != 0, decrement cnt. If cnt == 0, perform the access and go to RESP with resp_valid <= 1.
    - Read: resp_rdata <= line.
    - Write: all line words are updated; resp_rdata is held unchanged.
  - RESP: resp_valid = 1. resp_rdata is stable until handshake. On resp_ready, clear resp_valid and go to IDLE. req_ready = 0 throughout, so there is a mandatory one-cycle bubble before the next accept.
- Latency: a request accepted at edge k is accessed at edge k+LATENCY+1. resp_valid is high from that edge onward.
- req_valid while req_ready = 0 is ignored (not queued).
- Reset mid-operation: an in-flight request is dropped. A write aborted in WAIT never modifies the array. A pending response is discarded.
- Read-after-write: a read accepted after a write's response is handshaken returns the written data.

Optional Feature:
MEM_BYTE_MASK_EN
- Defined: adds input port req_wmask, width (DATA_W/8)<<LINE_LOG2, packed in the same order as req_wdata. On a write, only bytes whose mask bit is 1 are updated; bytes with mask bit 0 keep their old value. Mask is ignored on reads.
- Undefined: the port is absent and every write updates the full line.

Test Plan:
1. Preload word i = i; LATENCY=2. After reset, read req_addr=0x05 accepted at edge k -> resp_valid high after edge k+3; resp_rdata = {4,5,6,7} (word 4 in MSBs).
2. Write req_addr=0x08, wdata {A,B,C,D} (hex words 0xA..0xD); handshake ack; then read 0x0B -> {A,B,C,D}. Read 0x04 -> {4,5,6,7} unchanged.
3. Read 0x10 with resp_ready held 0 for 5 cycles while req_valid=1 on a second request -> resp_valid and resp_rdata = {16,17,18,19} stable; req_ready = 0. The second request is only accepted two edges after resp_ready rises (bubble).
4. Write 0x00 with {F,F,F,F}; assert rst for one cycle while in WAIT -> resp_valid 0 and req_ready 1 after the reset edge; subsequent read 0x00 -> {0,1,2,3}.
5. Read req_addr=0x41 and 0xFFFFFFC1 -> both return {0,1,2,3} (wrap). Repeat with LATENCY=0 -> resp_valid one edge after accept.
6. With MEM_BYTE_MASK_EN: write 0x00, wdata all 0xFFFFFFFF, mask selecting only the least significant byte of word 3 -> read 0x00 returns {0,1,2,0x000000FF}.

Source files
------------

// File: rtl/line_memory.sv
// Line-granular backing memory with a valid/ready request/response handshake and fixed access latency.
// Optional per-byte write enables are compiled in with `define MEM_BYTE_MASK_EN (adds port req_wmask).
module line_memory #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter int unsigned LINE_LOG2  = 2,
    parameter int unsigned LATENCY    = 2,
    parameter string       INIT_FILE  = ""
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_write,
    input  logic [ADDR_W-1:0]               req_addr,
    input  logic [(DATA_W<<LINE_LOG2)-1:0]  req_wdata,
`ifdef MEM_BYTE_MASK_EN
    input  logic [((DATA_W/8)<<LINE_LOG2)-1:0] req_wmask,
`endif
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic [(DATA_W<<LINE_LOG2)-1:0]  resp_rdata,
    output logic                            busy
);

    localparam int unsigned Words    = 1 << LINE_LOG2;
    localparam int unsigned Depth    = 1 << DEPTH_LOG2;
    localparam int unsigned LineW    = DATA_W * Words;
    localparam int unsigned Bpw      = DATA_W / 8;
    localparam int unsigned MaskW    = Bpw * Words;
    localparam int unsigned LineIdxW = DEPTH_LOG2 - LINE_LOG2;
    localparam int unsigned CntW     = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [LineIdxW-1:0] line_q, line_d;
    logic                write_q, write_d;
    logic [LineW-1:0]    wdata_q, wdata_d;
    logic [MaskW-1:0]    wmask_q, wmask_d;
    logic [LineW-1:0]    rdata_q, rdata_d;
    logic [LineW-1:0]    rd_line;
    logic                do_access;

    logic [DATA_W-1:0] mem_q [Depth];

    // Address bits outside the line index are deliberately ignored (wrap, line-aligned access).
    logic unused_addr;
    assign unused_addr = ^{req_addr[ADDR_W-1:DEPTH_LOG2], req_addr[LINE_LOG2-1:0]};

    assign do_access = (state_q == StWait) && (cnt_q == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req_valid) state_d = StWait;
            StWait:  if (cnt_q == '0) state_d = StResp;
            StResp:  if (resp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StResp);
        busy       = (state_q != StIdle);
        resp_rdata = rdata_q;
    end

    // Word 0 of a line sits in the most significant slice.
    always_comb begin
        rd_line = '0;
        for (int unsigned w = 0; w < Words; w++) begin
            rd_line[(Words-1-w)*DATA_W +: DATA_W] = mem_q[{line_q, LINE_LOG2'(w)}];
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        line_d  = line_q;
        write_d = write_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        if (state_q == StIdle && req_valid) begin
            cnt_d   = CntW'(LATENCY);
            line_d  = req_addr[DEPTH_LOG2-1:LINE_LOG2];
            write_d = req_write;
            wdata_d = req_wdata;
`ifdef MEM_BYTE_MASK_EN
            wmask_d = req_wmask;
`else
            wmask_d = '1;
`endif
        end else if (state_q == StWait && cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end else if (do_access && !write_q) begin
            rdata_d = rd_line;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        line_q  <= line_d;
        write_q <= write_d;
        wdata_q <= wdata_d;
        wmask_q <= wmask_d;
    end

    // Array is never cleared by reset; a reset on the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && do_access && write_q) begin
            for (int unsigned w = 0; w < Words; w++) begin
                for (int unsigned b = 0; b < Bpw; b++) begin
                    if (wmask_q[(Words-1-w)*Bpw + b]) begin
                        mem_q[{line_q, LINE_LOG2'(w)}][b*8 +: 8] <=
                            wdata_q[(Words-1-w)*DATA_W + b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule
